// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron spike source and its downstream sink.
// No logic; types and constants only.
// Both sides of the 4-phase channel agree on these encodings.
package neuron_pkg;

    // Default width of the spike weight carried with each request.
    localparam int NEURON_DATA_W = 8;

    // Source-side handshake controller states.
    typedef logic [1:0] src_state_t;
    localparam src_state_t SRC_IDLE   = 2'd0;
    localparam src_state_t SRC_SETUP  = 2'd1;
    localparam src_state_t SRC_REQ_HI = 2'd2;
    localparam src_state_t SRC_REQ_LO = 2'd3;

    // 4-phase channel phases, encoded as {req, ack}.
    typedef logic [1:0] hs_phase_t;
    localparam hs_phase_t PH_IDLE    = 2'b00;  // channel at rest
    localparam hs_phase_t PH_REQ     = 2'b10;  // request raised, data valid
    localparam hs_phase_t PH_ACK     = 2'b11;  // receiver has latched data
    localparam hs_phase_t PH_RELEASE = 2'b01;  // request dropped, ack pending release

    // Current phase of a channel given its two wires.
    function automatic hs_phase_t hs_phase(input logic req, input logic ack);
        return {req, ack};
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer for an input asynchronous to clk.
// Latency: STAGES clk edges from a stable input to q.
// No backpressure; level signal only.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Chain clears to 0 so a stale level is never assumed present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/neuron_spike_src.sv
// Buffers weighted spikes from a valid/ready port and issues them on a 4-phase bundled-data req/ack channel.
// Latency: push to pop 1 edge, pop to req rise SETUP_CYCLES edges; ack seen SYNC_STAGES edges after it rises.
// Backpressure: in_ready drops when the FIFO holds FIFO_DEPTH events; it is driven only by registered occupancy.
module neuron_spike_src
    import neuron_pkg::*;
#(
    parameter int DATA_W       = NEURON_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req_out,
    input  logic              ack_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SC_W  = $clog2(SETUP_CYCLES + 1);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [SC_W-1:0]  SC_LOAD  = SC_W'(SETUP_CYCLES);
    localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Event FIFO: storage, pointers that wrap naturally (depth is a power
    // of two) and an explicit occupancy count for full/empty.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    assign in_ready   = (occ_q != OCC_FULL);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (occ_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // Next FIFO state; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // FIFO registers; reset leaves the queue empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge synchronizer. The controller never looks at raw ack.
    // ------------------------------------------------------------------
    logic ack_sync;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_out),
        .q   (ack_sync)
    );

    // ------------------------------------------------------------------
    // 4-phase handshake controller.
    // data_out is only loaded on a pop, which happens only in IDLE or
    // REQ_LO with ack_sync low, so the bundle never moves under an
    // outstanding request or acknowledge.
    // ------------------------------------------------------------------
    src_state_t        state_q, state_d;
    logic [SC_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  sent_q, sent_d;

    // Next controller state, counters and channel outputs.
    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        req_d       = req_q;
        data_d      = data_q;
        sent_d      = sent_q;
        pop         = 1'b0;
        case (state_q)
            SRC_IDLE: begin
                // A stale ack left over from a reset holds us here.
                if (!fifo_empty && !ack_sync) begin
                    pop         = 1'b1;
                    data_d      = head;
                    setup_cnt_d = SC_LOAD;
                    state_d     = SRC_SETUP;
                end
            end
            SRC_SETUP: begin
                // Data has been on the bus for SETUP_CYCLES edges once the
                // counter reaches its last count.
                if (setup_cnt_q == SC_ONE) begin
                    setup_cnt_d = '0;
                    req_d       = 1'b1;
                    state_d     = SRC_REQ_HI;
                end else begin
                    setup_cnt_d = setup_cnt_q - SC_ONE;
                end
            end
            SRC_REQ_HI: begin
                if (ack_sync) begin
                    req_d   = 1'b0;
                    sent_d  = sent_q + CNT_ONE;
                    state_d = SRC_REQ_LO;
                end
            end
            SRC_REQ_LO: begin
                // Return-to-zero: wait for the neuron to drop ack, then
                // go straight into the next event if one is queued.
                if (!ack_sync) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        data_d      = head;
                        setup_cnt_d = SC_LOAD;
                        state_d     = SRC_SETUP;
                    end else begin
                        state_d = SRC_IDLE;
                    end
                end
            end
            default: begin
                state_d = SRC_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Controller registers; reset drops req immediately and clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SRC_IDLE;
            setup_cnt_q <= '0;
            req_q       <= 1'b0;
            data_q      <= '0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            req_q       <= req_d;
            data_q      <= data_d;
            sent_q      <= sent_d;
        end
    end

    assign req_out    = req_q;
    assign data_out   = data_q;
    assign sent_count = sent_q;
    assign busy       = (state_q != SRC_IDLE) || !fifo_empty;

endmodule
